// File: rtl/blackbox_sweeper_if.sv
// Bundle between the sweeper and its surroundings: sweep control, the probe
// lines to the external 3-input cell, and the characterisation results.
interface blackbox_sweeper_if;
   logic       start;
   logic       abort;
   logic [7:0] expected;
   logic       probe_q;
   logic       probe_i;
   logic       probe_f;
   logic       probe_u;
   logic       busy;
   logic       done;
   logic [7:0] table_out;
   logic       mismatch;
   logic [2:0] fail_idx;

   modport master (
      output start, abort, expected, probe_u,
      input  probe_q, probe_i, probe_f, busy, done, table_out, mismatch, fail_idx
   );

   modport slave (
      input  start, abort, expected, probe_u,
      output probe_q, probe_i, probe_f, busy, done, table_out, mismatch, fail_idx
   );
endinterface

// File: rtl/blackbox_sweeper.sv
// Walks all eight input vectors through an external 3-input cell, records its
// truth table and flags the first vector that disagrees with a golden table.
module blackbox_sweeper #(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input logic               clock,
   input logic               reset,
   blackbox_sweeper_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   state_t     stateQ;
   logic [2:0] idxQ;
   logic [3:0] cntQ;
   logic [7:0] expQ;
   logic [7:0] tableQ;
   logic       mismatchQ;
   logic [2:0] failIdxQ;
   logic       busyQ;
   logic       doneQ;

   // The vector index doubles as the probe drive, so the probes are always
   // exactly the vector being characterised and fall to zero on abort.
   always_ff @(posedge clock) begin
      if (reset) begin
         stateQ    <= IDLE;
         idxQ      <= 3'd0;
         cntQ      <= 4'd0;
         expQ      <= 8'd0;
         tableQ    <= 8'd0;
         mismatchQ <= 1'b0;
         failIdxQ  <= 3'd0;
         busyQ     <= 1'b0;
         doneQ     <= 1'b0;
      end else begin
         case (stateQ)
            IDLE: begin
               if (bus.start) begin
                  expQ      <= bus.expected;
                  idxQ      <= 3'd0;
                  cntQ      <= 4'd0;
                  tableQ    <= 8'd0;
                  mismatchQ <= 1'b0;
                  failIdxQ  <= 3'd0;
                  busyQ     <= 1'b1;
                  stateQ    <= SETTLE;
               end
            end
            SETTLE: begin
               if (bus.abort) begin
                  stateQ <= IDLE;
                  busyQ  <= 1'b0;
                  idxQ   <= 3'd0;
                  cntQ   <= 4'd0;
               end else if (cntQ == SETTLE_LAST) begin
                  stateQ <= SAMPLE;
               end else begin
                  cntQ <= cntQ + 4'd1;
               end
            end
            SAMPLE: begin
               if (bus.abort) begin
                  stateQ <= IDLE;
                  busyQ  <= 1'b0;
                  idxQ   <= 3'd0;
                  cntQ   <= 4'd0;
               end else begin
                  tableQ[idxQ] <= bus.probe_u;
                  // Only the first disagreement is reported; later ones are dropped.
                  if ((bus.probe_u != expQ[idxQ]) && !mismatchQ) begin
                     mismatchQ <= 1'b1;
                     failIdxQ  <= idxQ;
                  end
                  if (idxQ == 3'd7) begin
                     stateQ <= DONE;
                     doneQ  <= 1'b1;
                     busyQ  <= 1'b0;
                  end else begin
                     idxQ   <= idxQ + 3'd1;
                     cntQ   <= 4'd0;
                     stateQ <= SETTLE;
                  end
               end
            end
            DONE: begin
               doneQ  <= 1'b0;
               stateQ <= IDLE;
            end
            default: stateQ <= IDLE;
         endcase
      end
   end

   assign bus.probe_q   = idxQ[2];
   assign bus.probe_i   = idxQ[1];
   assign bus.probe_f   = idxQ[0];
   assign bus.busy      = busyQ;
   assign bus.done      = doneQ;
   assign bus.table_out = tableQ;
   assign bus.mismatch  = mismatchQ;
   assign bus.fail_idx  = failIdxQ;

endmodule

// File: tb/tb_blackbox_sweeper.sv
// Directed bench: one sweeper with default settling drives a real or stubbed
// cell, a second with three settle cycles is used for the probe trace.
module tb_blackbox_sweeper;

   logic clock;
   logic reset;
   logic stubMode;
   int   checks;
   int   errors;

   blackbox_sweeper_if bif ();
   blackbox_sweeper_if bif3 ();

   blackbox_sweeper dut (
      .clock (clock),
      .reset (reset),
      .bus   (bif.slave)
   );

   blackbox_sweeper #(.SETTLE_CYCLES(3)) dut3 (
      .clock (clock),
      .reset (reset),
      .bus   (bif3.slave)
   );

   // Cell under characterisation: u = ~q | ~f | i, or a stub tied high.
   assign bif.probe_u  = stubMode ? 1'b1 : (~bif.probe_q | ~bif.probe_f | bif.probe_i);
   assign bif3.probe_u = ~bif3.probe_q | ~bif3.probe_f | bif3.probe_i;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic stepCycle();
      @(posedge clock);
      #1;
   endtask

   task automatic startSweep(input logic [7:0] exp);
      bif.expected = exp;
      bif.start    = 1'b1;
      stepCycle();
      bif.start    = 1'b0;
   endtask

   // Cycle 1 is the cycle right after the start edge; returns 0 on timeout.
   task automatic waitDone(input int fromCyc, output int cyc);
      bit found;
      found = 1'b0;
      cyc   = 0;
      for (int c = fromCyc; c <= 100; c++) begin
         if (!found && bif.done) begin
            cyc   = c;
            found = 1'b1;
         end
         if (!found) stepCycle();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      stepCycle();
      stepCycle();
      reset = 1'b0;
      checks++; if (bif.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0b want 0", bif.busy); end
      checks++; if (bif.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %0b want 0", bif.done); end
      checks++; if (bif.table_out !== 8'h00) begin errors++; $display("[TB] FAIL reset_table got %h want 00", bif.table_out); end
      checks++; if (bif.mismatch !== 1'b0) begin errors++; $display("[TB] FAIL reset_mismatch got %0b want 0", bif.mismatch); end
      checks++; if (bif.fail_idx !== 3'd0) begin errors++; $display("[TB] FAIL reset_fail_idx got %0d want 0", bif.fail_idx); end
      checks++; if ({bif.probe_q, bif.probe_i, bif.probe_f} !== 3'd0) begin errors++; $display("[TB] FAIL reset_probes got %0d want 0", {bif.probe_q, bif.probe_i, bif.probe_f}); end
   endtask

   task automatic test_real_match();
      int cyc;
      stubMode = 1'b0;
      startSweep(8'hDF);
      checks++; if (bif.busy !== 1'b1) begin errors++; $display("[TB] FAIL match_busy got %0b want 1", bif.busy); end
      waitDone(1, cyc);
      checks++; if (cyc !== 25) begin errors++; $display("[TB] FAIL match_done_cycle got %0d want 25", cyc); end
      checks++; if (bif.table_out !== 8'hDF) begin errors++; $display("[TB] FAIL match_table got %h want df", bif.table_out); end
      checks++; if (bif.mismatch !== 1'b0) begin errors++; $display("[TB] FAIL match_mismatch got %0b want 0", bif.mismatch); end
      checks++; if (bif.fail_idx !== 3'd0) begin errors++; $display("[TB] FAIL match_fail_idx got %0d want 0", bif.fail_idx); end
      checks++; if (bif.busy !== 1'b0) begin errors++; $display("[TB] FAIL match_busy_done got %0b want 0", bif.busy); end
      stepCycle();
      checks++; if (bif.done !== 1'b0) begin errors++; $display("[TB] FAIL match_done_pulse got %0b want 0", bif.done); end
   endtask

   task automatic test_real_mismatch();
      int cyc;
      startSweep(8'hFF);
      waitDone(1, cyc);
      checks++; if (cyc !== 25) begin errors++; $display("[TB] FAIL mism_done_cycle got %0d want 25", cyc); end
      checks++; if (bif.table_out !== 8'hDF) begin errors++; $display("[TB] FAIL mism_table got %h want df", bif.table_out); end
      checks++; if (bif.mismatch !== 1'b1) begin errors++; $display("[TB] FAIL mism_mismatch got %0b want 1", bif.mismatch); end
      checks++; if (bif.fail_idx !== 3'd5) begin errors++; $display("[TB] FAIL mism_fail_idx got %0d want 5", bif.fail_idx); end
      for (int i = 0; i < 6; i++) stepCycle();
      checks++; if ({bif.table_out, bif.mismatch, bif.fail_idx} !== {8'hDF, 1'b1, 3'd5}) begin errors++; $display("[TB] FAIL mism_hold got %h/%0b/%0d want df/1/5", bif.table_out, bif.mismatch, bif.fail_idx); end
   endtask

   task automatic test_stub();
      int cyc;
      stubMode = 1'b1;
      startSweep(8'h00);
      waitDone(1, cyc);
      checks++; if (cyc !== 25) begin errors++; $display("[TB] FAIL stub_done_cycle got %0d want 25", cyc); end
      checks++; if (bif.table_out !== 8'hFF) begin errors++; $display("[TB] FAIL stub_table got %h want ff", bif.table_out); end
      checks++; if (bif.mismatch !== 1'b1) begin errors++; $display("[TB] FAIL stub_mismatch got %0b want 1", bif.mismatch); end
      checks++; if (bif.fail_idx !== 3'd0) begin errors++; $display("[TB] FAIL stub_fail_idx got %0d want 0", bif.fail_idx); end
      stepCycle();
      stubMode = 1'b0;
   endtask

   task automatic test_probe_trace();
      logic [2:0] want;
      bif3.expected = 8'hDF;
      bif3.start    = 1'b1;
      stepCycle();
      bif3.start    = 1'b0;
      for (int c = 1; c <= 32; c++) begin
         want = 3'((c - 1) / 4);
         checks++; if ({bif3.probe_q, bif3.probe_i, bif3.probe_f} !== want) begin errors++; $display("[TB] FAIL trace_probe cycle %0d got %0d want %0d", c, {bif3.probe_q, bif3.probe_i, bif3.probe_f}, want); end
         stepCycle();
      end
      checks++; if (bif3.done !== 1'b1) begin errors++; $display("[TB] FAIL trace_done_cycle33 got %0b want 1", bif3.done); end
      checks++; if (bif3.table_out !== 8'hDF) begin errors++; $display("[TB] FAIL trace_table got %h want df", bif3.table_out); end
      stepCycle();
   endtask

   task automatic test_abort();
      int cyc;
      bit doneSeen;
      startSweep(8'hDF);
      for (int i = 1; i < 10; i++) stepCycle();
      bif.abort = 1'b1;
      stepCycle();
      bif.abort = 1'b0;
      checks++; if (bif.busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got %0b want 0", bif.busy); end
      checks++; if ({bif.probe_q, bif.probe_i, bif.probe_f} !== 3'd0) begin errors++; $display("[TB] FAIL abort_probes got %0d want 0", {bif.probe_q, bif.probe_i, bif.probe_f}); end
      checks++; if (bif.table_out !== 8'h07) begin errors++; $display("[TB] FAIL abort_partial_table got %h want 07", bif.table_out); end
      doneSeen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (bif.done) doneSeen = 1'b1;
         stepCycle();
      end
      checks++; if (doneSeen !== 1'b0) begin errors++; $display("[TB] FAIL abort_no_done got %0b want 0", doneSeen); end
      startSweep(8'hFF);
      waitDone(1, cyc);
      checks++; if (cyc !== 25) begin errors++; $display("[TB] FAIL abort_restart_cycle got %0d want 25", cyc); end
      checks++; if ({bif.table_out, bif.mismatch, bif.fail_idx} !== {8'hDF, 1'b1, 3'd5}) begin errors++; $display("[TB] FAIL abort_restart_results got %h/%0b/%0d want df/1/5", bif.table_out, bif.mismatch, bif.fail_idx); end
      stepCycle();
      // start and abort together in IDLE: the sweep must still begin.
      bif.expected = 8'hDF;
      bif.abort    = 1'b1;
      bif.start    = 1'b1;
      stepCycle();
      bif.start    = 1'b0;
      bif.abort    = 1'b0;
      checks++; if (bif.busy !== 1'b1) begin errors++; $display("[TB] FAIL abort_with_start_busy got %0b want 1", bif.busy); end
      waitDone(1, cyc);
      checks++; if (cyc !== 25) begin errors++; $display("[TB] FAIL abort_with_start_cycle got %0d want 25", cyc); end
      stepCycle();
   endtask

   task automatic test_reset_mid();
      startSweep(8'h00);
      for (int i = 1; i < 12; i++) stepCycle();
      checks++; if (bif.mismatch !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_pre_mismatch got %0b want 1", bif.mismatch); end
      reset = 1'b1;
      stepCycle();
      reset = 1'b0;
      checks++; if ({bif.busy, bif.done, bif.mismatch} !== 3'b000) begin errors++; $display("[TB] FAIL rstmid_flags got %b want 000", {bif.busy, bif.done, bif.mismatch}); end
      checks++; if (bif.table_out !== 8'h00) begin errors++; $display("[TB] FAIL rstmid_table got %h want 00", bif.table_out); end
      checks++; if (bif.fail_idx !== 3'd0) begin errors++; $display("[TB] FAIL rstmid_fail_idx got %0d want 0", bif.fail_idx); end
      checks++; if ({bif.probe_q, bif.probe_i, bif.probe_f} !== 3'd0) begin errors++; $display("[TB] FAIL rstmid_probes got %0d want 0", {bif.probe_q, bif.probe_i, bif.probe_f}); end
      for (int i = 0; i < 5; i++) stepCycle();
      checks++; if (bif.busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_stays_idle got %0b want 0", bif.busy); end
   endtask

   task automatic test_back_to_back();
      int cyc;
      startSweep(8'hDF);
      for (int i = 1; i < 5; i++) stepCycle();
      bif.expected = 8'h00;
      bif.start    = 1'b1;
      stepCycle();
      bif.start    = 1'b0;
      waitDone(6, cyc);
      checks++; if (cyc !== 25) begin errors++; $display("[TB] FAIL b2b_ignored_start_cycle got %0d want 25", cyc); end
      checks++; if ({bif.table_out, bif.mismatch} !== {8'hDF, 1'b0}) begin errors++; $display("[TB] FAIL b2b_latched_expected got %h/%0b want df/0", bif.table_out, bif.mismatch); end
      stepCycle();
      startSweep(8'hFF);
      checks++; if (bif.busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_restart_busy got %0b want 1", bif.busy); end
      checks++; if (bif.mismatch !== 1'b0) begin errors++; $display("[TB] FAIL b2b_restart_cleared got %0b want 0", bif.mismatch); end
      waitDone(1, cyc);
      checks++; if (cyc !== 25) begin errors++; $display("[TB] FAIL b2b_restart_cycle got %0d want 25", cyc); end
      checks++; if (bif.fail_idx !== 3'd5) begin errors++; $display("[TB] FAIL b2b_restart_fail_idx got %0d want 5", bif.fail_idx); end
      stepCycle();
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      stubMode      = 1'b0;
      reset         = 1'b1;
      bif.start     = 1'b0;
      bif.abort     = 1'b0;
      bif.expected  = 8'h00;
      bif3.start    = 1'b0;
      bif3.abort    = 1'b0;
      bif3.expected = 8'h00;
      #1;
      test_reset();
      test_real_match();
      test_real_mismatch();
      test_stub();
      test_probe_trace();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Safety net so a stuck design can never hang the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired got running want finished");
      $fatal(1, "[TB] watchdog");
   end

endmodule
